// File: rtl/prog_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_arb_pkg
// Description : Shared types and constants for the program/data memory
//               data-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_arb_pkg;

  // Well-known requester slots
  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;

  // Width of an owner id for n requesters (never below 1 bit)
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One requester's memory transaction payload
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/prog_mem_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_owner_fifo
// Description : Small FIFO of owner ids for granted-but-unanswered memory
//               transactions. A push is accepted at full when a pop happens
//               in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_owner_fifo #(
  parameter int OWNER_W = 1,
  parameter int MAX_OUT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [OWNER_W-1:0] data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [OWNER_W-1:0] head_o
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(MAX_OUT);

  logic [OWNER_W-1:0] r_mem [MAX_OUT];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full_o    = (r_count == C_DEPTH);
  assign empty_o   = (r_count == '0);
  assign head_o    = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Pointer and occupancy tracking, pointers wrap modulo MAX_OUT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Owner storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/prog_mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_data_arbiter
// Description : Round-robin arbiter sharing the memory data port between
//               NUM_REQ requesters, with in-order response routing through
//               an owner FIFO of depth MAX_OUT.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_data_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] addr_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*4-1:0]  be_i,
  input  logic [NUM_REQ*32-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  err_o
);

  import prog_mem_arb_pkg::*;

  localparam int OWNER_W = owner_w(NUM_REQ);
  localparam logic [OWNER_W-1:0] C_LAST_REQ = OWNER_W'(NUM_REQ - 1);

  logic [OWNER_W-1:0] r_rr_ptr;
  logic               r_err;
  logic [OWNER_W-1:0] w_sel;
  logic               w_found;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [OWNER_W-1:0] w_head;
  logic               w_pop;
  logic               w_full_eff;
  logic               w_grant;
  mem_req_t           w_slot [NUM_REQ];
  mem_req_t           w_pick;

  // Unpack the flat per-requester buses into payload structs
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign w_slot[i] = '{addr:  addr_i[32*i +: 32],
                         we:    we_i[i],
                         be:    be_i[4*i +: 4],
                         wdata: wdata_i[32*i +: 32]};
  end

  // Round-robin select: first active request at or above rr pointer, wrapping
  always_comb begin : p_select
    int w_idx;
    w_idx   = 0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_sel   = OWNER_W'(w_idx);
      end
    end
  end

  assign w_pick = w_slot[w_sel];

  // A response frees a FIFO slot in the same cycle, so a full FIFO can still grant
  assign w_pop      = mem_rvalid_i & ~w_fifo_empty;
  assign w_full_eff = w_fifo_full & ~w_pop;
  assign mem_req_o  = rst_ni & w_found & ~w_full_eff;
  assign w_grant    = mem_req_o & mem_gnt_i;

  assign gnt_o    = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
  assign rvalid_o = (rst_ni & w_pop) ? (NUM_REQ'(1) << w_head) : '0;
  assign rdata_o  = mem_rdata_i;
  assign err_o    = r_err;

  // Payload is forced to zero whenever no request is presented to memory
  assign mem_addr_o  = mem_req_o ? w_pick.addr  : '0;
  assign mem_we_o    = mem_req_o ? w_pick.we    : 1'b0;
  assign mem_be_o    = mem_req_o ? w_pick.be    : '0;
  assign mem_wdata_o = mem_req_o ? w_pick.wdata : '0;

  // Rotate priority past the winner on every grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_sel == C_LAST_REQ) ? '0 : w_sel + 1'b1;
    end
  end

  // Sticky error: memory answered with no transaction outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (mem_rvalid_i && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  prog_mem_owner_fifo #(
    .OWNER_W (OWNER_W),
    .MAX_OUT (MAX_OUT)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_grant),
    .data_i  (w_sel),
    .pop_i   (w_pop),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .head_o  (w_head)
  );

endmodule
`default_nettype wire
